// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - execute-stage handshake bundle for the divide sequencer
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               signed_i;
  logic               flush_i;
  logic               hold_i;
  logic [WIDTH-1:0]   opa_i;
  logic [WIDTH-1:0]   opb_i;
  logic               stall_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  // Pipeline side: issues the divide and consumes the result
  modport master (
    output start_i, signed_i, flush_i, hold_i, opa_i, opb_i,
    input  stall_o, ready_o, result_o
  );

  // Divider side
  modport slave (
    input  start_i, signed_i, flush_i, hold_i, opa_i, opb_i,
    output stall_o, ready_o, result_o
  );
endinterface

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle restoring divider sequencer for DIV/DIVU
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  div_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t             state;
  state_t             nextState;
  logic [5:0]         iterCount;
  logic [WIDTH-1:0]   opaQ;
  logic [WIDTH-1:0]   opbQ;
  logic               signedQ;
  logic [WIDTH-1:0]   quoReg;
  logic [WIDTH-1:0]   remReg;
  logic [2*WIDTH-1:0] resultReg;

  logic               accept;
  logic               lastStep;
  logic               fits;
  logic [WIDTH-1:0]   opaMag;
  logic [WIDTH-1:0]   divisorMag;
  logic [WIDTH:0]     partial;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   stepQuo;
  logic [WIDTH-1:0]   stepRem;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;

  assign accept     = bus.start_i && !bus.flush_i;
  assign opaMag     = (bus.signed_i && bus.opa_i[WIDTH-1]) ? -bus.opa_i : bus.opa_i;
  assign divisorMag = (signedQ && opbQ[WIDTH-1]) ? -opbQ : opbQ;

  // The dividend magnitude lives in quoReg and is shifted out MSB-first while
  // quotient bits shift in at the bottom. A borrow out of diff means the
  // partial remainder is smaller than the divisor, so the step is restored.
  assign partial  = {remReg, quoReg[WIDTH-1]};
  assign diff     = partial - {1'b0, divisorMag};
  assign fits     = !diff[WIDTH];
  assign stepRem  = fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  assign stepQuo  = {quoReg[WIDTH-2:0], fits};
  assign lastStep = (iterCount == 6'(WIDTH - 1));

  // Quotient negative when signs differ; remainder follows the dividend sign.
  // Two's-complement wrap makes MIN / -1 come out as MIN with no trap.
  assign quoFix = (signedQ && (opaQ[WIDTH-1] ^ opbQ[WIDTH-1])) ? -stepQuo : stepQuo;
  assign remFix = (signedQ && opaQ[WIDTH-1]) ? -stepRem : stepRem;

  // Stall is gated by reset so the hazard unit sees a quiet divider in reset
  assign bus.stall_o  = rst && !bus.flush_i &&
                        ((state == IDLE && bus.start_i) || state == ON || state == DIVZERO);
  assign bus.ready_o  = (state == END);
  assign bus.result_o = resultReg;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; flush overrides everything, including a new start
  always_comb begin
    nextState = state;
    if (bus.flush_i) begin
      nextState = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (bus.start_i) nextState = (bus.opb_i != '0) ? ON : DIVZERO;
        ON:      if (lastStep) nextState = END;
        DIVZERO: nextState = END;
        END:     if (!bus.hold_i) nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iterCount <= '0;
      opaQ      <= '0;
      opbQ      <= '0;
      signedQ   <= 1'b0;
      quoReg    <= '0;
      remReg    <= '0;
      resultReg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            opaQ      <= bus.opa_i;
            opbQ      <= bus.opb_i;
            signedQ   <= bus.signed_i;
            quoReg    <= opaMag;
            remReg    <= '0;
            iterCount <= '0;
          end
        end
        ON: begin
          if (!bus.flush_i) begin
            quoReg    <= stepQuo;
            remReg    <= stepRem;
            iterCount <= iterCount + 6'd1;
            if (lastStep) resultReg <= {remFix, quoFix};
          end
        end
        DIVZERO: begin
          if (!bus.flush_i) resultReg <= {opaQ, {WIDTH{1'b1}}};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - self-checking bench for div_sequencer
module tb_div_sequencer;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
  } vec_t;

  logic        clk;
  logic        rst;
  int          checks;
  int          errors;
  logic [63:0] lastRes;
  logic [63:0] sbQ[$];
  vec_t        vecs[11];

  div_sequencer_if #(.WIDTH(32)) bus ();

  div_sequencer #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Wait for ready_o, counting cycles and stall cycles; operands are scrambled
  // after T0 so a divider that fails to latch them gives a wrong answer.
  task automatic waitReady(output int cyc, output int stalls);
    cyc = 0;
    stalls = 0;
    while (bus.ready_o !== 1'b1 && cyc < 100) begin
      if (bus.stall_o === 1'b1) stalls++;
      @(negedge clk);
      cyc++;
      bus.opa_i    = $urandom;
      bus.opb_i    = $urandom;
      bus.signed_i = 1'($urandom_range(0, 1));
      #1;
    end
  endtask

  task automatic startDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] res);
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.signed_i = sgn;
    bus.opa_i    = a;
    bus.opb_i    = b;
    bus.flush_i  = 1'b0;
    bus.hold_i   = 1'b0;
    sbQ.push_back(res);
    #1;
  endtask

  task automatic popCheck(input string name);
    logic [63:0] exp;
    if (sbQ.size() == 0) begin
      check({name, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      exp = sbQ.pop_front();
      check(name, bus.result_o, exp);
      lastRes = exp;
    end
  endtask

  task automatic runDiv(input vec_t v, input int idx);
    int cyc;
    int stalls;
    int expLat;
    expLat = (v.b == 32'd0) ? 2 : 33;
    startDiv(v.sgn, v.a, v.b, v.res);
    waitReady(cyc, stalls);
    check($sformatf("latency_%0d", idx), 64'(cyc), 64'(expLat));
    check($sformatf("stalls_%0d", idx), 64'(stalls), 64'(expLat));
    check($sformatf("stall_at_ready_%0d", idx), 64'(bus.stall_o), 64'd0);
    popCheck($sformatf("result_%0d", idx));
    bus.start_i = 1'b0;
  endtask

  task automatic expectQuiet(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1 || bus.stall_o === 1'b1) seen++;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int cyc;
    int stalls;
    checks  = 0;
    errors  = 0;
    lastRes = 64'd0;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD};
    vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          64'h00000005_FFFFFFFF};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF};
    vecs[5]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
    vecs[6]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003};
    vecs[7]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC};
    vecs[8]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          64'hFFFFFFFB_FFFFFFFF};
    vecs[9]  = '{1'b0, 32'd3,          32'd10,         64'h00000003_00000000};
    vecs[10] = '{1'b0, 32'h80000000,   32'h80000000,   64'h00000000_00000001};

    // Reset state, with start_i high to show stall_o is held low in reset
    rst          = 1'b0;
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.flush_i  = 1'b0;
    bus.hold_i   = 1'b0;
    bus.opa_i    = 32'd9;
    bus.opb_i    = 32'd3;
    #12;
    check("reset_stall", 64'(bus.stall_o), 64'd0);
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    rst         = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) runDiv(vecs[i], i);

    // Flush at T10: stall drops that cycle, IDLE afterwards, no ready, result kept
    startDiv(1'b0, 32'd1000, 32'd3, 64'd0);
    void'(sbQ.pop_back());
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    #1;
    check("flush_stall_t10", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
    #1;
    check("flush_idle_t11", 64'(bus.stall_o), 64'd0);
    expectQuiet("flush_no_ready", 40);
    check("flush_result_kept", bus.result_o, lastRes);

    // Flush together with start: flush wins, nothing starts
    startDiv(1'b0, 32'd50, 32'd5, 64'd0);
    void'(sbQ.pop_back());
    bus.flush_i = 1'b1;
    #1;
    check("flush_start_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
    expectQuiet("flush_start_quiet", 40);

    // Hold at T33 for 3 cycles keeps END for 4 cycles with a stable result
    startDiv(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    waitReady(cyc, stalls);
    check("hold_latency", 64'(cyc), 64'd33);
    bus.start_i = 1'b0;
    bus.hold_i  = 1'b1;
    popCheck("hold_result");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hold_ready_%0d", i), 64'(bus.ready_o), 64'd1);
      check($sformatf("hold_stable_%0d", i), bus.result_o, 64'h00000002_0000000E);
      if (i == 3) bus.hold_i = 1'b0;
      @(negedge clk);
    end
    check("hold_released", 64'(bus.ready_o), 64'd0);

    // Reset at T20 clears outputs at once and leaves no pending result
    startDiv(1'b1, 32'hFFFFFFF9, 32'd2, 64'd0);
    void'(sbQ.pop_back());
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_stall", 64'(bus.stall_o), 64'd0);
    check("midreset_ready", 64'(bus.ready_o), 64'd0);
    check("midreset_result", bus.result_o, 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    rst         = 1'b1;
    expectQuiet("midreset_no_ready", 50);
    check("midreset_sb_empty", 64'(sbQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
